register_read: RTL

- Operand-fetch stage of the pipelined processor: the read side of the write-back path.
- Holds the architectural register file, which is written by the packed {address, value} write-back bus.
- Serves two source-operand reads per instruction, with same-cycle bypass from write-back.
- Presents operands to execute through one valid/ready pipeline register, kept coherent with write-backs that land during a stall.

---
 rtl/register_read.sv | 124 ++++++++++++
 1 files changed

// File: rtl/register_read.sv
// Operand-fetch stage: architectural register file with write-back bypass and a
// single valid/ready operand register kept coherent with write-backs during stalls.
module register_read #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [ADDR_W+DATA_W-1:0] wb_reg_address_and_value,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        rs1_addr,
    input  logic [ADDR_W-1:0]        rs2_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_rs1_addr,
    output logic [ADDR_W-1:0]        out_rs2_addr,
    output logic [DATA_W-1:0]        out_rs1_value,
    output logic [DATA_W-1:0]        out_rs2_value
);

    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_value;
    logic              wb_write;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic              out_valid_q,     out_valid_d;
    logic [ADDR_W-1:0] out_rs1_addr_q,  out_rs1_addr_d;
    logic [ADDR_W-1:0] out_rs2_addr_q,  out_rs2_addr_d;
    logic [DATA_W-1:0] out_rs1_value_q, out_rs1_value_d;
    logic [DATA_W-1:0] out_rs2_value_q, out_rs2_value_d;

    logic [DATA_W-1:0] rs1_value;
    logic [DATA_W-1:0] rs2_value;
    logic              accept;
    logic              stall;

    assign wb_addr  = wb_reg_address_and_value[ADDR_W+DATA_W-1:DATA_W];
    assign wb_value = wb_reg_address_and_value[DATA_W-1:0];
    assign wb_write = wb_valid && (wb_addr != '0);

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign stall    = out_valid_q && !out_ready;

    // Source reads: r0 is hard-wired zero, an in-flight write-back wins over the file.
    always_comb begin
        rs1_value = regs_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_value = '0;
        end else if (wb_write && (wb_addr == rs1_addr)) begin
            rs1_value = wb_value;
        end
        rs2_value = regs_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_value = '0;
        end else if (wb_write && (wb_addr == rs2_addr)) begin
            rs2_value = wb_value;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_write) begin
            regs_d[wb_addr] = wb_value;
        end
    end

    always_comb begin
        out_valid_d     = out_valid_q;
        out_rs1_addr_d  = out_rs1_addr_q;
        out_rs2_addr_d  = out_rs2_addr_q;
        out_rs1_value_d = out_rs1_value_q;
        out_rs2_value_d = out_rs2_value_q;
        if (accept) begin
            out_valid_d     = 1'b1;
            out_rs1_addr_d  = rs1_addr;
            out_rs2_addr_d  = rs2_addr;
            out_rs1_value_d = rs1_value;
            out_rs2_value_d = rs2_value;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else if (stall) begin
            // Held operands track write-backs so execute never sees a stale value.
            if (wb_write && (wb_addr == out_rs1_addr_q)) begin
                out_rs1_value_d = wb_value;
            end
            if (wb_write && (wb_addr == out_rs2_addr_q)) begin
                out_rs2_value_d = wb_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            out_valid_q     <= 1'b0;
            out_rs1_addr_q  <= '0;
            out_rs2_addr_q  <= '0;
            out_rs1_value_q <= '0;
            out_rs2_value_q <= '0;
        end else begin
            regs_q          <= regs_d;
            out_valid_q     <= out_valid_d;
            out_rs1_addr_q  <= out_rs1_addr_d;
            out_rs2_addr_q  <= out_rs2_addr_d;
            out_rs1_value_q <= out_rs1_value_d;
            out_rs2_value_q <= out_rs2_value_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_rs1_addr  = out_rs1_addr_q;
    assign out_rs2_addr  = out_rs2_addr_q;
    assign out_rs1_value = out_rs1_value_q;
    assign out_rs2_value = out_rs2_value_q;

endmodule
